// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one LX32 ALU between two requesters,
// with a single registered result stage tagged by source and requester tag.
package lx32_alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;
endpackage

module alu_arbiter
  import lx32_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  alu_op_e          req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  alu_op_e          req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output alu_op_e          alu_control,
  output logic [WIDTH-1:0] alu_src_a,
  output logic [WIDTH-1:0] alu_src_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_src
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_src_q, rsp_src_d;
  logic             last_grant_q, last_grant_d;

  logic grant_vld_s;
  logic grant_s;
  logic can_accept_s;
  logic xfer_s;

  // Grant selection: on contention the requester not served last wins.
  always_comb begin
    grant_vld_s  = req0_valid | req1_valid;
    can_accept_s = ~rsp_valid_q | rsp_ready;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_q;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    xfer_s     = grant_vld_s & can_accept_s & ~rst;
    req0_ready = xfer_s & ~grant_s;
    req1_ready = xfer_s & grant_s;
  end

  // ALU operand mux; idles on ADD 0,0 when nobody requests.
  always_comb begin
    if (!grant_vld_s) begin
      alu_control = ALU_ADD;
      alu_src_a   = {WIDTH{1'b0}};
      alu_src_b   = {WIDTH{1'b0}};
    end else if (grant_s) begin
      alu_control = req1_op;
      alu_src_a   = req1_a;
      alu_src_b   = req1_b;
    end else begin
      alu_control = req0_op;
      alu_src_a   = req0_a;
      alu_src_b   = req0_b;
    end
  end

  // Result stage next state: a new transfer overwrites, otherwise drain or hold.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_src_d    = rsp_src_q;
    last_grant_d = last_grant_q;
    if (xfer_s) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = alu_result;
      rsp_tag_d    = grant_s ? req1_tag : req0_tag;
      rsp_src_d    = grant_s;
      last_grant_d = grant_s;
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // State registers; reset points last_grant at req1 so req0 wins first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= {WIDTH{1'b0}};
      rsp_tag_q    <= {TAG_W{1'b0}};
      rsp_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_src_q    <= rsp_src_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_src    = rsp_src_q;

endmodule
